// File: rtl/perf_event_counters.sv
// perf_event_counters: event counter bank plus cycle counter with halt freeze, atomic snapshot and registered readback
module perf_event_counters #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter int SAT    = 0,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ev,
  input  logic              halt,
  input  logic              clr,
  input  logic              snap_req,
  output logic              snap_vld,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic              running,
  output logic              halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_cnt [NUM_CH+1];
  logic [CNT_W-1:0] r_shd [NUM_CH+1];
  logic [CNT_W-1:0] w_nxt [NUM_CH+1];
  logic [NUM_CH:0] w_inc, w_wrap;
  logic [CNT_W-1:0] w_rd;
  logic w_run, w_halt_now, w_snap;
  assign w_run      = r_state == RUN;
  assign w_inc      = w_run ? {1'b1, ev} : '0;
  assign w_halt_now = w_run && halt;
  // entering HALTED takes an implicit snapshot so final counts need no snap_req
  assign w_snap     = snap_req || w_halt_now;
  always_comb begin
    w_rd   = '0;
    w_wrap = '0;
    for (int i = 0; i <= NUM_CH; i++) begin
      w_wrap[i] = w_inc[i] && (r_cnt[i] == '1);
      w_nxt[i]  = (w_inc[i] && !(SAT != 0 && w_wrap[i])) ? r_cnt[i] + 1'b1 : r_cnt[i];
      if (rd_sel == SEL_W'(i)) w_rd = r_shd[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      running  <= 1'b0;
      halted   <= 1'b0;
      snap_vld <= 1'b0;
      ovf      <= '0;
      rd_data  <= '0;
      for (int i = 0; i <= NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_shd[i] <= '0;
      end
    end else begin
      rd_data <= w_rd;
      if (clr) begin
        r_state  <= IDLE;
        running  <= 1'b0;
        halted   <= 1'b0;
        snap_vld <= 1'b0;
        ovf      <= '0;
        for (int i = 0; i <= NUM_CH; i++) begin
          r_cnt[i] <= '0;
          r_shd[i] <= '0;
        end
      end else begin
        for (int i = 0; i <= NUM_CH; i++) begin
          r_cnt[i] <= w_nxt[i];
          if (w_snap) r_shd[i] <= w_nxt[i];
        end
        ovf <= ovf | w_wrap;
        if (w_snap) snap_vld <= 1'b1;
        if (r_state == IDLE && start) begin
          r_state <= RUN;
          running <= 1'b1;
        end else if (w_halt_now) begin
          r_state <= HALTED;
          running <= 1'b0;
          halted  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_perf_event_counters.sv
// tb_perf_event_counters: vector table plus scoreboarded readback checks on a default and two narrow counter banks
module tb_perf_event_counters;
  logic clk = 0, rst = 1, start = 0, halt = 0, clr = 0, snap_req = 0;
  logic [5:0] ev = '0;
  logic [3:0] rd_sel = '0;
  logic snap_vld, running, halted, sv_w, run_w, hlt_w, sv_s, run_s, hlt_s;
  logic [31:0] rd_data;
  logic [6:0] ovf;
  logic [3:0] rd_w, rd_s, ovf_w, ovf_s;
  int nchk = 0, nbad = 0;

  always #5 clk = ~clk;

  perf_event_counters dut (.clk(clk), .rst(rst), .start(start), .ev(ev), .halt(halt), .clr(clr),
    .snap_req(snap_req), .snap_vld(snap_vld), .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf),
    .running(running), .halted(halted));
  perf_event_counters #(.NUM_CH(3), .CNT_W(4), .SAT(0), .SEL_W(3)) dut_w (.clk(clk), .rst(rst),
    .start(start), .ev(ev[2:0]), .halt(halt), .clr(clr), .snap_req(snap_req), .snap_vld(sv_w),
    .rd_sel(rd_sel[2:0]), .rd_data(rd_w), .ovf(ovf_w), .running(run_w), .halted(hlt_w));
  perf_event_counters #(.NUM_CH(3), .CNT_W(4), .SAT(1), .SEL_W(3)) dut_s (.clk(clk), .rst(rst),
    .start(start), .ev(ev[2:0]), .halt(halt), .clr(clr), .snap_req(snap_req), .snap_vld(sv_s),
    .rd_sel(rd_sel[2:0]), .rd_data(rd_s), .ovf(ovf_s), .running(run_s), .halted(hlt_s));

  typedef struct { string name; int who; logic [31:0] exp; } sb_t;
  sb_t sb [$];
  typedef struct { logic [3:0] sel; logic [31:0] exp; } vec_t;
  vec_t tv [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_of(input int who);
    return who == 0 ? rd_data : who == 1 ? {28'd0, rd_w} : {28'd0, rd_s};
  endfunction

  // drive rd_sel, queue expectation, then compare once the registered read emerges
  task automatic rd(input logic [3:0] sel, input int who, input logic [31:0] exp, input string name);
    sb_t e;
    rd_sel = sel;
    sb.push_back('{name, who, exp});
    tick();
    e = sb.pop_front();
    check(e.name, rd_of(e.who), e.exp);
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic pulse_clr();
    clr = 1; tick(); clr = 0;
  endtask

  initial begin
    tv[0] = '{4'd0, 32'd10}; tv[1] = '{4'd1, 32'd0}; tv[2] = '{4'd2, 32'd0};
    tv[3] = '{4'd3, 32'd0};  tv[4] = '{4'd4, 32'd0}; tv[5] = '{4'd5, 32'd0};
    tv[6] = '{4'd6, 32'd10}; tv[7] = '{4'd0, 32'd10}; tv[8] = '{4'd15, 32'd0};
    tick(); tick();
    check("rst_running", {31'd0, running}, 0);
    check("rst_rd", rd_data, 0);
    check("rst_ovf", {25'd0, ovf}, 0);
    rst = 0;
    tick();
    // T1: ten counted cycles, halt on the tenth
    pulse_start();
    check("t1_running", {31'd0, running}, 1);
    for (int k = 1; k <= 10; k++) begin
      ev = 6'b000001; halt = (k == 10); tick();
    end
    ev = '0; halt = 0;
    check("t1_halted", {31'd0, halted}, 1);
    check("t1_running_off", {31'd0, running}, 0);
    check("t1_snap_vld", {31'd0, snap_vld}, 1);
    // T2: events after halt must not change anything
    for (int k = 0; k < 5; k++) begin
      ev = 6'h3F; tick();
    end
    ev = '0;
    rd_sel = 4'd15; tick();
    for (int i = 0; i < 9; i++) begin
      logic [31:0] prev;
      prev = (i == 0) ? 32'd0 : tv[i-1].exp;
      rd_sel = tv[i].sel;
      #1 check($sformatf("t2_lag%0d", i), rd_data, prev);
      rd(tv[i].sel, 0, tv[i].exp, $sformatf("t2_sel%0d", tv[i].sel));
    end
    check("t2_ovf", {25'd0, ovf}, 0);
    // T4: snapshot with same-cycle increment, then clear winning over everything
    pulse_clr();
    check("t4_clr_halted", {31'd0, halted}, 0);
    check("t4_clr_vld", {31'd0, snap_vld}, 0);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      ev = 6'b000010; tick();
    end
    ev = 6'b000010; snap_req = 1;
    rd(1, 0, 0, "t4_snap_old");
    ev = '0; snap_req = 0;
    rd(1, 0, 4, "t4_snap_new");
    check("t4_vld", {31'd0, snap_vld}, 1);
    clr = 1; ev = 6'b000010; snap_req = 1; tick();
    clr = 0; ev = '0; snap_req = 0;
    check("t4_clr_vld2", {31'd0, snap_vld}, 0);
    check("t4_clr_idle", {30'd0, running, halted}, 0);
    rd(1, 0, 0, "t4_clr_ch1");
    rd(6, 0, 0, "t4_clr_cyc");
    // T5: priorities
    start = 1; halt = 1; tick(); start = 0; halt = 0;
    check("t5_start_halt", {30'd0, running, halted}, 2);
    clr = 1; halt = 1; tick(); clr = 0; halt = 0;
    check("t5_clr_halt", {30'd0, running, halted}, 0);
    // T3: 4-bit counters, wrap vs saturate
    pulse_start();
    for (int k = 0; k < 17; k++) begin
      ev = 6'b000100; tick();
    end
    ev = '0; snap_req = 1; tick(); snap_req = 0;
    rd(2, 1, 1, "t3_wrap_ch2");
    rd(2, 2, 15, "t3_sat_ch2");
    check("t3_wrap_ovf", {28'd0, ovf_w}, 32'hC);
    check("t3_sat_ovf", {28'd0, ovf_s}, 32'hC);
    check("t3_main_ovf", {25'd0, ovf}, 0);
    // T6: select range on the three-channel banks (cycle count 18 runs)
    rd(3, 1, 2, "t6_wrap_cyc");
    rd(3, 2, 15, "t6_sat_cyc");
    rd(7, 1, 0, "t6_wrap_oob");
    rd(7, 2, 0, "t6_sat_oob");
    // asynchronous reset mid-run drops everything
    pulse_clr();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      ev = 6'b000001; tick();
    end
    snap_req = 1; tick(); ev = '0; snap_req = 0;
    rd(0, 0, 4, "rst_pre_rd");
    #2 rst = 1;
    #1 check("rst_async_rd", rd_data, 0);
    check("rst_async_state", {29'd0, running, halted, snap_vld}, 0);
    #1 rst = 0;
    rd(0, 0, 0, "rst_shadow");
    rd(6, 0, 0, "rst_cyc_shadow");
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
